// File: rtl/dual_issue_ctrl_pkg.sv
// rtl/dual_issue_ctrl_pkg.sv - shared CPU constants: RV32 opcodes, issue-controller state and slot types
package dual_issue_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic {
        ST_PAIR  = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } slot_t;

endpackage

// File: rtl/pair_hazard_check.sv
// rtl/pair_hazard_check.sv - flags decode pairs that cannot issue together in one cycle
module pair_hazard_check
    import dual_issue_ctrl_pkg::*;
(
    input  logic [31:0] InstrD1,
    input  logic [31:0] InstrD2,
    output logic        conflict
);

    logic [6:0] op1;
    logic [6:0] op2;
    logic [4:0] rd1;
    logic [4:0] rs1_2;
    logic [4:0] rs2_2;
    logic       d1_writes_rd;
    logic       d2_reads_rs1;
    logic       d2_reads_rs2;
    logic       raw_hazard;
    logic       mem_pair;
    logic       d1_ctrl;
    logic       unused_bits;

    assign op1   = InstrD1[6:0];
    assign op2   = InstrD2[6:0];
    assign rd1   = InstrD1[11:7];
    assign rs1_2 = InstrD2[19:15];
    assign rs2_2 = InstrD2[24:20];

    assign d1_writes_rd = (op1 == OP_R)   || (op1 == OP_IMM) || (op1 == OP_LOAD) ||
                          (op1 == OP_JAL) || (op1 == OP_JALR) || (op1 == OP_LUI) ||
                          (op1 == OP_AUIPC);
    assign d2_reads_rs1 = !((op2 == OP_LUI) || (op2 == OP_AUIPC) || (op2 == OP_JAL));
    assign d2_reads_rs2 = (op2 == OP_R) || (op2 == OP_STORE) || (op2 == OP_BRANCH);

    // x0 never carries a dependency, so a write to it cannot stall D2
    assign raw_hazard = d1_writes_rd && (rd1 != 5'd0) &&
                        ((d2_reads_rs1 && (rs1_2 == rd1)) ||
                         (d2_reads_rs2 && (rs2_2 == rd1)));

    assign mem_pair = ((op1 == OP_LOAD) || (op1 == OP_STORE)) &&
                      ((op2 == OP_LOAD) || (op2 == OP_STORE));

    assign d1_ctrl = (op1 == OP_BRANCH) || (op1 == OP_JAL) || (op1 == OP_JALR);

    assign conflict = raw_hazard || mem_pair || d1_ctrl;

    assign unused_bits = ^{InstrD1[31:12], InstrD2[31:25], InstrD2[14:12]};

endmodule

// File: rtl/dual_issue_ctrl.sv
// rtl/dual_issue_ctrl.sv - dual-issue decode-to-execute controller with pair splitting
module dual_issue_ctrl
    import dual_issue_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_d,
    input  logic [31:0]      InstrD1,
    input  logic [31:0]      InstrD2,
    input  logic [31:0]      PCD1,
    input  logic [31:0]      PCD2,
    input  logic             PCSrcE,
    input  logic             ex_ready,
    output logic             issue1_valid,
    output logic             issue2_valid,
    output logic [31:0]      issue1_instr,
    output logic [31:0]      issue2_instr,
    output logic [31:0]      issue1_pc,
    output logic [31:0]      issue2_pc,
    output logic             stall_f,
    output logic             flush_d,
    output logic [CNT_W-1:0] split_cnt
);

    state_t           state_q, state_d;
    slot_t            slot1_q, slot1_d;
    slot_t            slot2_q, slot2_d;
    slot_t            hold_q,  hold_d;
    logic             v1_q, v1_d;
    logic             v2_q, v2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             conflict;

    pair_hazard_check u_hazard (
        .InstrD1  (InstrD1),
        .InstrD2  (InstrD2),
        .conflict (conflict)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_PAIR;
            slot1_q <= '0;
            slot2_q <= '0;
            hold_q  <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            slot1_q <= slot1_d;
            slot2_q <= slot2_d;
            hold_q  <= hold_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (PCSrcE) begin
            state_d = ST_PAIR;
        end else if (ex_ready) begin
            case (state_q)
                ST_PAIR:  if (valid_d && conflict) state_d = ST_SPLIT;
                ST_SPLIT: state_d = ST_PAIR;
                default:  state_d = ST_PAIR;
            endcase
        end
    end

    // Redirect beats back-pressure, which beats normal issue
    always_comb begin
        slot1_d = slot1_q;
        slot2_d = slot2_q;
        hold_d  = hold_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
        cnt_d   = cnt_q;
        stall_f = 1'b0;
        if (PCSrcE) begin
            v1_d   = 1'b0;
            v2_d   = 1'b0;
            hold_d = '0;
        end else if (!ex_ready) begin
            stall_f = 1'b1;
        end else if (state_q == ST_SPLIT) begin
            v1_d    = 1'b0;
            v2_d    = 1'b1;
            slot2_d = hold_q;
            hold_d  = '0;
        end else if (valid_d) begin
            v1_d    = 1'b1;
            slot1_d = '{instr: InstrD1, pc: PCD1};
            if (conflict) begin
                stall_f = 1'b1;
                v2_d    = 1'b0;
                hold_d  = '{instr: InstrD2, pc: PCD2};
                if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                v2_d    = 1'b1;
                slot2_d = '{instr: InstrD2, pc: PCD2};
            end
        end else begin
            v1_d = 1'b0;
            v2_d = 1'b0;
        end
    end

    assign flush_d      = PCSrcE;
    assign issue1_valid = v1_q;
    assign issue2_valid = v2_q;
    assign issue1_instr = slot1_q.instr;
    assign issue1_pc    = slot1_q.pc;
    assign issue2_instr = slot2_q.instr;
    assign issue2_pc    = slot2_q.pc;
    assign split_cnt    = cnt_q;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// tb/tb_dual_issue_ctrl.sv - randomized and directed bench for dual_issue_ctrl against a queue-based model
module tb_dual_issue_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             valid_d;
    logic [31:0]      InstrD1;
    logic [31:0]      InstrD2;
    logic [31:0]      PCD1;
    logic [31:0]      PCD2;
    logic             PCSrcE;
    logic             ex_ready;
    logic             issue1_valid;
    logic             issue2_valid;
    logic [31:0]      issue1_instr;
    logic [31:0]      issue2_instr;
    logic [31:0]      issue1_pc;
    logic [31:0]      issue2_pc;
    logic             stall_f;
    logic             flush_d;
    logic [CNT_W-1:0] split_cnt;

    dual_issue_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_d      (valid_d),
        .InstrD1      (InstrD1),
        .InstrD2      (InstrD2),
        .PCD1         (PCD1),
        .PCD2         (PCD2),
        .PCSrcE       (PCSrcE),
        .ex_ready     (ex_ready),
        .issue1_valid (issue1_valid),
        .issue2_valid (issue2_valid),
        .issue1_instr (issue1_instr),
        .issue2_instr (issue2_instr),
        .issue1_pc    (issue1_pc),
        .issue2_pc    (issue2_pc),
        .stall_f      (stall_f),
        .flush_d      (flush_d),
        .split_cnt    (split_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a pending queue of D2 instructions waiting for a slot stands in for the FSM
    logic [31:0] pend_instr[$];
    logic [31:0] pend_pc[$];
    bit          e_v1, e_v2;
    logic [31:0] e_i1, e_p1, e_i2, e_p2;
    int          e_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_conflict(input logic [31:0] a, input logic [31:0] b);
        logic [6:0] oa = a[6:0];
        logic [6:0] ob = b[6:0];
        logic [4:0] rd = a[11:7];
        bit wr  = oa inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111,
                             7'b1100111, 7'b0110111, 7'b0010111};
        bit r1  = !(ob inside {7'b0110111, 7'b0010111, 7'b1101111});
        bit r2  = ob inside {7'b0110011, 7'b0100011, 7'b1100011};
        bit raw = wr && (rd != 5'd0) && ((r1 && b[19:15] == rd) || (r2 && b[24:20] == rd));
        bit mem = (oa inside {7'b0000011, 7'b0100011}) && (ob inside {7'b0000011, 7'b0100011});
        bit ctl = oa inside {7'b1100011, 7'b1101111, 7'b1100111};
        return raw || mem || ctl;
    endfunction

    task automatic model_reset();
        pend_instr.delete();
        pend_pc.delete();
        e_v1 = 0; e_v2 = 0;
        e_i1 = '0; e_p1 = '0; e_i2 = '0; e_p2 = '0;
        e_cnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".v1"}, 32'(issue1_valid), 32'(e_v1));
        check({tag, ".v2"}, 32'(issue2_valid), 32'(e_v2));
        if (e_v1) begin
            check({tag, ".i1"}, issue1_instr, e_i1);
            check({tag, ".p1"}, issue1_pc, e_p1);
        end
        if (e_v2) begin
            check({tag, ".i2"}, issue2_instr, e_i2);
            check({tag, ".p2"}, issue2_pc, e_p2);
        end
        check({tag, ".cnt"}, 32'(split_cnt), 32'(e_cnt));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".v1"}, 32'(issue1_valid), 32'd0);
        check({tag, ".v2"}, 32'(issue2_valid), 32'd0);
        check({tag, ".i1"}, issue1_instr, 32'd0);
        check({tag, ".i2"}, issue2_instr, 32'd0);
        check({tag, ".p1"}, issue1_pc, 32'd0);
        check({tag, ".p2"}, issue2_pc, 32'd0);
        check({tag, ".cnt"}, 32'(split_cnt), 32'd0);
    endtask

    task automatic cycle(input string tag);
        bit conf, exp_stall;
        @(negedge clk);
        conf      = ref_conflict(InstrD1, InstrD2);
        exp_stall = !PCSrcE && (!ex_ready || (pend_instr.size() == 0 && valid_d && conf));
        check({tag, ".stall_f"}, 32'(stall_f), 32'(exp_stall));
        check({tag, ".flush_d"}, 32'(flush_d), 32'(PCSrcE));
        if (PCSrcE) begin
            e_v1 = 0; e_v2 = 0;
            pend_instr.delete();
            pend_pc.delete();
        end else if (!ex_ready) begin
        end else if (pend_instr.size() > 0) begin
            e_v1 = 0; e_v2 = 1;
            e_i2 = pend_instr.pop_front();
            e_p2 = pend_pc.pop_front();
        end else if (valid_d) begin
            e_v1 = 1; e_i1 = InstrD1; e_p1 = PCD1;
            if (conf) begin
                e_v2 = 0;
                pend_instr.push_back(InstrD2);
                pend_pc.push_back(PCD2);
                e_cnt = (e_cnt < CNT_MAX) ? e_cnt + 1 : CNT_MAX;
            end else begin
                e_v2 = 1; e_i2 = InstrD2; e_p2 = PCD2;
            end
        end else begin
            e_v1 = 0; e_v2 = 0;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic set_in(input logic v, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] pc, input logic er, input logic br);
        valid_d  = v;
        InstrD1  = d1;
        InstrD2  = d2;
        PCD1     = pc;
        PCD2     = pc + 32'd4;
        ex_ready = er;
        PCSrcE   = br;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check_all_zero("reset");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 8)]};
    endfunction

    initial begin
        set_in(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        check_all_zero("por");
        check("por.stall_f", 32'(stall_f), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // independent adds issue together
        set_in(1'b1, 32'h003100B3, 32'h00628233, 32'h100, 1'b1, 1'b0);
        cycle("pair");
        check("pair.p1", issue1_pc, 32'h100);
        check("pair.p2", issue2_pc, 32'h104);
        check("pair.both", 32'({issue1_valid, issue2_valid}), 32'd3);

        // RAW on x1 splits the pair
        set_in(1'b1, 32'h003100B3, 32'h00508233, 32'h200, 1'b1, 1'b0);
        cycle("raw1");
        check("raw1.only1", 32'({issue1_valid, issue2_valid}), 32'd2);
        cycle("raw2");
        check("raw2.only2", 32'({issue1_valid, issue2_valid}), 32'd1);
        check("raw2.instr", issue2_instr, 32'h00508233);
        check("raw2.cnt", 32'(split_cnt), 32'd1);

        // load followed by store
        set_in(1'b1, 32'h00012283, 32'h0061A223, 32'h300, 1'b1, 1'b0);
        cycle("mem1");
        cycle("mem2");

        // writes to x0 carry no dependency
        set_in(1'b1, 32'h00310033, 32'h00500233, 32'h400, 1'b1, 1'b0);
        cycle("x0");
        check("x0.both", 32'({issue1_valid, issue2_valid}), 32'd3);

        // redirect while a D2 is held drops it
        set_in(1'b1, 32'h003100B3, 32'h00508233, 32'h500, 1'b1, 1'b0);
        cycle("br0");
        PCSrcE = 1'b1;
        cycle("br1");
        set_in(1'b0, 32'd0, 32'd0, 32'h600, 1'b1, 1'b0);
        cycle("br2");
        check("br2.none", 32'({issue1_valid, issue2_valid}), 32'd0);

        // back-pressure while split freezes everything
        set_in(1'b1, 32'h003100B3, 32'h00508233, 32'h700, 1'b1, 1'b0);
        cycle("bp0");
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle("bp_hold");
        ex_ready = 1'b1;
        cycle("bp_rel");

        // reset in SPLIT acts immediately and nothing is issued afterwards
        set_in(1'b1, 32'h003100B3, 32'h00508233, 32'h800, 1'b1, 1'b0);
        cycle("rs0");
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("rs_mid");
        model_reset();
        #1;
        rst = 1'b1;
        set_in(1'b0, 32'd0, 32'd0, 32'h900, 1'b1, 1'b0);
        cycle("rs1");
        cycle("rs2");

        // saturation: branch in D1 always splits
        do_reset();
        set_in(1'b1, 32'h00000063, 32'h00628233, 32'hA00, 1'b1, 1'b0);
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            cycle("sat_a");
            cycle("sat_b");
        end
        check("sat.cnt", 32'(split_cnt), 32'(CNT_MAX));

        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 99) < 85), rand_instr(), rand_instr(),
                   {$urandom_range(0, 255), 2'b00}, 1'($urandom_range(0, 99) < 80),
                   1'($urandom_range(0, 99) < 10));
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
